// File: rtl/ccff_bitstream_loader_if.sv
// Word handshake between the programming interface and the CCFF bitstream loader.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ccff_bitstream_loader.sv
// CCFF bitstream loader: takes words over a valid/ready handshake and shifts
// exactly CHAIN_LEN bits, LSB first, into the configuration-chain head. Every
// output is a register; ccff_shift_en gates prog_clk to the chain.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic                           prog_clk,
    input  logic                           prog_reset,
    input  logic                           start,
    input  logic                           abort,
    ccff_bitstream_loader_if.slave         bus,
    output logic                           ccff_head,
    output logic                           ccff_shift_en,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bits_left
);
    localparam int BL_W = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BL_W-1:0]   cnt_q, cnt_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic              in_ready_q, in_ready_d;
    logic              head_q, head_d;
    logic              shift_en_q, shift_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BL_W-1:0]   k;

    // Bits to take from the word just accepted: a full word, or the remainder
    // when fewer than WORD_W bits are left (upper bits of that word are dropped).
    always_comb begin
        k = bits_left_q;
        if (32'(bits_left_q) >= WORD_W) begin
            k = BL_W'(WORD_W);
        end
    end

    // Next-state and registered-output logic. The first bit of a word is
    // presented on the same edge that accepts it, so cnt_q counts the shifts
    // still to come after the one currently on ccff_head.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        bits_left_d = bits_left_q;
        in_ready_d  = in_ready_q;
        head_d      = head_q;
        shift_en_d  = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;

        if (abort) begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            bits_left_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d     = S_LOAD;
                        bits_left_d = BL_W'(CHAIN_LEN);
                        done_d      = 1'b0;
                        busy_d      = 1'b1;
                        in_ready_d  = 1'b1;
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid && in_ready_q) begin
                        state_d     = S_SHIFT;
                        in_ready_d  = 1'b0;
                        head_d      = bus.in_data[0];
                        sreg_d      = bus.in_data >> 1;
                        shift_en_d  = 1'b1;
                        bits_left_d = bits_left_q - BL_W'(1);
                        cnt_d       = k - BL_W'(1);
                    end
                end
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        head_d      = sreg_q[0];
                        sreg_d      = sreg_q >> 1;
                        shift_en_d  = 1'b1;
                        bits_left_d = bits_left_q - BL_W'(1);
                        cnt_d       = cnt_q - BL_W'(1);
                    end else if (bits_left_q == '0) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_LOAD;
                        in_ready_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q     <= S_IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            bits_left_q <= '0;
            in_ready_q  <= 1'b0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            bits_left_q <= bits_left_d;
            in_ready_q  <= in_ready_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign ccff_head      = head_q;
    assign ccff_shift_en  = shift_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign bits_left      = bits_left_q;
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader: DUT A (20 bits / 8-bit words)
// and DUT B (16 bits / 8-bit words). Stimulus pushes the hand-computed serial
// bits; per-DUT monitors pop one bit on every shift-enabled cycle.
module tb_ccff_bitstream_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Expected serial streams, LSB of each word first.
    // A: 0xA5, 0x3C, low nibble of 0xF9.  B: 0x5A, 0xC3.
    bit stream_a [20] = '{1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,0,0,1};
    bit stream_b [16] = '{0,1,0,1,1,0,1,0, 1,1,0,0,0,0,1,1};

    bit qa[$];
    bit qb[$];
    int exp_bl_a = 0, exp_bl_b = 0;
    int shifts_a = 0, shifts_b = 0;

    logic       rst_a, start_a, abort_a, head_a, shen_a, busy_a, done_a;
    logic [4:0] bl_a;
    logic       rst_b, start_b, abort_b, head_b, shen_b, busy_b, done_b;
    logic [4:0] bl_b;

    ccff_bitstream_loader_if #(.WORD_W(8)) bus_a ();
    ccff_bitstream_loader_if #(.WORD_W(8)) bus_b ();

    ccff_bitstream_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_a (
        .prog_clk(clk), .prog_reset(rst_a), .start(start_a), .abort(abort_a),
        .bus(bus_a), .ccff_head(head_a), .ccff_shift_en(shen_a),
        .busy(busy_a), .done(done_a), .bits_left(bl_a)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_b (
        .prog_clk(clk), .prog_reset(rst_b), .start(start_b), .abort(abort_b),
        .bus(bus_b), .ccff_head(head_b), .ccff_shift_en(shen_b),
        .busy(busy_b), .done(done_b), .bits_left(bl_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor A: every shift pops one expected bit and tracks bits_left.
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            if (shen_a === 1'b1) begin
                shifts_a++;
                exp_bl_a--;
                check("A bits_left during shift", 32'(bl_a), exp_bl_a);
                if (qa.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL A unexpected shift: got shift with head %0d, expected no shift", head_a);
                end else begin
                    e = qa.pop_front();
                    check("A ccff_head", 32'(head_a), 32'(e));
                end
            end
        end
    end

    // Monitor B.
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            if (shen_b === 1'b1) begin
                shifts_b++;
                exp_bl_b--;
                check("B bits_left during shift", 32'(bl_b), exp_bl_b);
                if (qb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL B unexpected shift: got shift with head %0d, expected no shift", head_b);
                end else begin
                    e = qb.pop_front();
                    check("B ccff_head", 32'(head_b), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input bit b);
        @(posedge clk); #1;
        if (b) begin start_b = 1'b1; exp_bl_b = 16; shifts_b = 0; end
        else   begin start_a = 1'b1; exp_bl_a = 20; shifts_a = 0; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Offer one word; push its expected bits when the handshake is seen.
    // Returns 1 time unit into the cycle after the accepting edge.
    task automatic send(input bit b, input logic [7:0] d, input int from, input int n);
        bit rdy = 1'b0;
        int t = 0;
        @(posedge clk); #1;
        if (b) begin bus_b.in_data = d; bus_b.in_valid = 1'b1; end
        else   begin bus_a.in_data = d; bus_a.in_valid = 1'b1; end
        while (!rdy && t < 100) begin
            @(negedge clk);
            rdy = b ? bus_b.in_ready : bus_a.in_ready;
            if (rdy) begin
                for (int i = 0; i < n; i++) begin
                    if (b) qb.push_back(stream_b[from + i]);
                    else   qa.push_back(stream_a[from + i]);
                end
            end
            @(posedge clk);
            t++;
        end
        #1;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        if (!rdy) begin
            checks++;
            fails++;
            $display("FAIL %s handshake timeout: got no in_ready in 100 cycles, expected in_ready", b ? "B" : "A");
        end
    endtask

    // After the final word's handshake: k shifts, then DONE on the next cycle.
    task automatic finish_check(input bit b, input int k, input int total);
        repeat (k - 1) @(negedge clk);
        @(negedge clk);
        check("last shift enable", 32'(b ? shen_b : shen_a), 1);
        check("done before last shift ends", 32'(b ? done_b : done_a), 0);
        @(negedge clk);
        check("done after last shift", 32'(b ? done_b : done_a), 1);
        check("busy after last shift", 32'(b ? busy_b : busy_a), 0);
        check("shift_en in DONE", 32'(b ? shen_b : shen_a), 0);
        check("in_ready in DONE", 32'(b ? bus_b.in_ready : bus_a.in_ready), 0);
        check("bits_left in DONE", 32'(b ? bl_b : bl_a), 0);
        check("total shifts", b ? shifts_b : shifts_a, total);
        check("scoreboard drained", b ? qb.size() : qa.size(), 0);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, " in_ready"}, 32'(bus_a.in_ready), 0);
        check({tag, " ccff_head"}, 32'(head_a), 0);
        check({tag, " shift_en"}, 32'(shen_a), 0);
        check({tag, " busy"}, 32'(busy_a), 0);
        check({tag, " done"}, 32'(done_a), 0);
        check({tag, " bits_left"}, 32'(bl_a), 0);
    endtask

    task automatic full_load_a();
        send(1'b0, 8'hA5, 0, 8);
        send(1'b0, 8'h3C, 8, 8);
        send(1'b0, 8'hF9, 16, 4);
        finish_check(1'b0, 4, 20);
    endtask

    initial begin
        int rdy_seen;
        rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0;
        rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0;
        bus_a.in_data = '0; bus_a.in_valid = 1'b0;
        bus_b.in_data = '0; bus_b.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check_reset_a("A reset");
        check("B reset busy", 32'(busy_b), 0);
        check("B reset bits_left", 32'(bl_b), 0);

        // Full load from IDLE.
        do_start(1'b0);
        @(negedge clk);
        check("A start busy", 32'(busy_a), 1);
        check("A start in_ready", 32'(bus_a.in_ready), 1);
        check("A start bits_left", 32'(bl_a), 20);
        full_load_a();

        // Restart from DONE, with a 5-cycle gap between words.
        do_start(1'b0);
        @(negedge clk);
        check("A restart done", 32'(done_a), 0);
        check("A restart in_ready", 32'(bus_a.in_ready), 1);
        check("A restart bits_left", 32'(bl_a), 20);
        send(1'b0, 8'hA5, 0, 8);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("A gap shift_en", 32'(shen_a), 0);
            check("A gap in_ready", 32'(bus_a.in_ready), 1);
        end
        send(1'b0, 8'h3C, 8, 8);
        send(1'b0, 8'hF9, 16, 4);
        finish_check(1'b0, 4, 20);

        // Abort on the 3rd shift of word 1.
        do_start(1'b0);
        send(1'b0, 8'hA5, 0, 8);
        send(1'b0, 8'h3C, 8, 8);
        @(posedge clk);
        @(posedge clk); #1;
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        qa.delete();
        @(negedge clk);
        check("A abort busy", 32'(busy_a), 0);
        check("A abort bits_left", 32'(bl_a), 0);
        check("A abort shift_en", 32'(shen_a), 0);
        check("A abort in_ready", 32'(bus_a.in_ready), 0);
        check("A abort done", 32'(done_a), 0);
        check("A shifts before abort", shifts_a, 11);
        bus_a.in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("A idle in_ready", 32'(bus_a.in_ready), 0);
        bus_a.in_valid = 1'b0;
        do_start(1'b0);
        @(negedge clk);
        check("A reload bits_left", 32'(bl_a), 20);
        full_load_a();

        // Reset pulse during SHIFT.
        do_start(1'b0);
        send(1'b0, 8'hA5, 0, 8);
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        qa.delete();
        @(negedge clk);
        check_reset_a("A mid-load reset");
        bus_a.in_valid = 1'b1;
        repeat (5) @(negedge clk);
        check("A post-reset in_ready", 32'(bus_a.in_ready), 0);
        check("A post-reset busy", 32'(busy_a), 0);
        bus_a.in_valid = 1'b0;

        // Exact-multiple length on DUT B, start ignored while shifting.
        do_start(1'b1);
        @(negedge clk);
        check("B start in_ready", 32'(bus_b.in_ready), 1);
        check("B start bits_left", 32'(bl_b), 16);
        send(1'b1, 8'h5A, 0, 8);
        @(posedge clk); #1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        @(negedge clk);
        check("B start-in-shift busy", 32'(busy_b), 1);
        check("B start-in-shift in_ready", 32'(bus_b.in_ready), 0);
        check("B start-in-shift shift_en", 32'(shen_b), 1);
        check("B start-in-shift bits_left", 32'(bl_b), 13);
        send(1'b1, 8'hC3, 8, 8);
        rdy_seen = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus_b.in_ready === 1'b1) rdy_seen++;
            if (i == 7) begin
                check("B last shift enable", 32'(shen_b), 1);
                check("B done before end", 32'(done_b), 0);
            end
        end
        check("B done after last shift", 32'(done_b), 1);
        check("B busy after last shift", 32'(busy_b), 0);
        check("B bits_left in DONE", 32'(bl_b), 0);
        check("B in_ready after word 2", rdy_seen, 0);
        check("B total shifts", shifts_b, 16);
        check("B scoreboard drained", qb.size(), 0);
        repeat (3) @(negedge clk);
        check("B done held", 32'(done_b), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
